// File: rtl/painterengine_gpu_dma_reader.sv
// AXI4 read master: fetches a word-aligned region for one of four channels in 1 KB-safe INCR bursts.
// Optional RLAST consistency check enabled by PAINTERENGINE_GPU_READER_RLAST_CHECK_EN.
module painterengine_gpu_dma_reader #(
  parameter int PARAM_DATA_ALIGN = 32
) (
  input  logic                          i_wire_clock,
  input  logic                          i_wire_resetn,
  input  logic [3:0]                    i_wire_router,
  output logic                          o_wire_done,
  input  logic [127:0]                  i_wire_address,
  input  logic [127:0]                  i_wire_length,
  output logic [4*PARAM_DATA_ALIGN-1:0] o_wire_data,
  output logic [3:0]                    o_wire_data_valid,
  input  logic [3:0]                    i_wire_data_next,
  output logic                          o_wire_error,
  output logic [2:0]                    o_wire_error_type,
  output logic                          o_wire_M_AXI_ARID,
  output logic [31:0]                   o_wire_M_AXI_ARADDR,
  output logic [7:0]                    o_wire_M_AXI_ARLEN,
  output logic [2:0]                    o_wire_M_AXI_ARSIZE,
  output logic [1:0]                    o_wire_M_AXI_ARBURST,
  output logic                          o_wire_M_AXI_ARLOCK,
  output logic [3:0]                    o_wire_M_AXI_ARCACHE,
  output logic [2:0]                    o_wire_M_AXI_ARPROT,
  output logic [3:0]                    o_wire_M_AXI_ARQOS,
  output logic                          o_wire_M_AXI_ARVALID,
  input  logic                          i_wire_M_AXI_ARREADY,
  input  logic                          i_wire_M_AXI_RID,
  input  logic [PARAM_DATA_ALIGN-1:0]   i_wire_M_AXI_RDATA,
  input  logic [1:0]                    i_wire_M_AXI_RRESP,
  input  logic                          i_wire_M_AXI_RLAST,
  input  logic                          i_wire_M_AXI_RVALID,
  output logic                          o_wire_M_AXI_RREADY
);

  typedef enum logic [4:0] {
    ST_ROUTING     = 5'h01,
    ST_PARAM_CHECK = 5'h02,
    ST_CALC        = 5'h03,
    ST_CALC2       = 5'h04,
    ST_ADDR        = 5'h05,
    ST_DATA        = 5'h06,
    ST_DONE        = 5'h07,
    ST_ERR         = 5'h10
  } state_t;

  state_t      state, state_next;
  logic [2:0]  err_type, err_next;
  logic [1:0]  idx, sel_idx;
  logic        sel_ok;
  logic [31:0] addr_r, len_r, offset, waddr, remaining, araddr_r;
  logic [8:0]  burst, beat_cnt, room, burst_calc, burst_m1;
  logic [7:0]  arlen_r;
  logic [15:0] tmo;
  logic [32:0] offset_sum;
  logic        in_data, rready_int, beat_fire, last_beat, ar_hs, wait_cyc, tmo_hit, resp_bad;
  logic        unused_sink;

  always_comb begin
    sel_ok  = 1'b1;
    sel_idx = 2'd0;
    case (i_wire_router)
      4'b0001: sel_idx = 2'd0;
      4'b0010: sel_idx = 2'd1;
      4'b0100: sel_idx = 2'd2;
      4'b1000: sel_idx = 2'd3;
      default: sel_ok  = 1'b0;
    endcase
  end

  assign in_data    = (state == ST_DATA);
  assign rready_int = in_data && i_wire_data_next[idx];
  assign beat_fire  = rready_int && i_wire_M_AXI_RVALID;
  assign ar_hs      = (state == ST_ADDR) && i_wire_M_AXI_ARREADY;
  assign resp_bad   = (i_wire_M_AXI_RRESP >= 2'd2);
  assign last_beat  = ((beat_cnt + 9'd1) == burst);
  assign offset_sum = {1'b0, offset} + {24'd0, burst};
  // Words left before the next 1 KB boundary; always 1..256.
  assign room       = 9'd256 - {1'b0, waddr[9:2]};
  assign burst_calc = (remaining < {23'd0, room}) ? remaining[8:0] : room;
  assign burst_m1   = burst_calc - 9'd1;
  // Consumer backpressure (RVALID high, next low) deliberately does not count.
  assign wait_cyc   = ((state == ST_ADDR) && !i_wire_M_AXI_ARREADY) ||
                      (in_data && !i_wire_M_AXI_RVALID);
  assign tmo_hit    = (tmo >= 16'd255);

`ifdef PAINTERENGINE_GPU_READER_RLAST_CHECK_EN
  logic rlast_err;
  assign rlast_err   = (i_wire_M_AXI_RLAST != last_beat);
  assign unused_sink = &{1'b0, i_wire_M_AXI_RID};
`else
  assign unused_sink = &{1'b0, i_wire_M_AXI_RID, i_wire_M_AXI_RLAST};
`endif

  always_comb begin
    state_next = state;
    err_next   = err_type;
    case (state)
      ST_ROUTING: begin
        if (i_wire_router != 4'd0) begin
          if (sel_ok) begin
            state_next = ST_PARAM_CHECK;
          end else begin
            state_next = ST_ERR;
            err_next   = 3'd1;
          end
        end
      end
      ST_PARAM_CHECK: begin
        if (addr_r[1:0] != 2'b00) begin
          state_next = ST_ERR;
          err_next   = 3'd2;
        end else if (len_r == 32'd0) begin
          state_next = ST_ERR;
          err_next   = 3'd3;
        end else begin
          state_next = ST_CALC;
        end
      end
      ST_CALC:  state_next = ST_CALC2;
      ST_CALC2: state_next = ST_ADDR;
      ST_ADDR: begin
        if (i_wire_M_AXI_ARREADY) begin
          state_next = ST_DATA;
        end else if (tmo_hit) begin
          state_next = ST_ERR;
          err_next   = 3'd4;
        end
      end
      ST_DATA: begin
        if (beat_fire) begin
          if (resp_bad) begin
            state_next = ST_ERR;
            err_next   = 3'd6;
          end
`ifdef PAINTERENGINE_GPU_READER_RLAST_CHECK_EN
          else if (rlast_err) begin
            state_next = ST_ERR;
            err_next   = 3'd7;
          end
`endif
          else if (last_beat) begin
            state_next = (offset_sum >= {1'b0, len_r}) ? ST_DONE : ST_CALC;
          end
        end else if (!i_wire_M_AXI_RVALID && tmo_hit) begin
          state_next = ST_ERR;
          err_next   = 3'd5;
        end
      end
      ST_DONE:  state_next = ST_DONE;
      ST_ERR:   state_next = ST_ERR;
      default:  state_next = ST_ROUTING;
    endcase
  end

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      state    <= ST_ROUTING;
      err_type <= 3'd0;
    end else begin
      state    <= state_next;
      err_type <= err_next;
    end
  end

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      idx       <= 2'd0;
      addr_r    <= 32'd0;
      len_r     <= 32'd0;
      offset    <= 32'd0;
      waddr     <= 32'd0;
      remaining <= 32'd0;
      burst     <= 9'd0;
      beat_cnt  <= 9'd0;
      araddr_r  <= 32'd0;
      arlen_r   <= 8'd0;
      tmo       <= 16'd0;
    end else begin
      case (state)
        ST_ROUTING: begin
          if (sel_ok) begin
            idx    <= sel_idx;
            addr_r <= i_wire_address[sel_idx*32 +: 32];
            len_r  <= i_wire_length[sel_idx*32 +: 32];
            offset <= 32'd0;
          end
        end
        ST_CALC: begin
          waddr     <= addr_r + {offset[29:0], 2'b00};
          remaining <= len_r - offset;
        end
        ST_CALC2: begin
          burst    <= burst_calc;
          araddr_r <= waddr;
          arlen_r  <= burst_m1[7:0];
        end
        ST_ADDR: begin
          if (i_wire_M_AXI_ARREADY) beat_cnt <= 9'd0;
        end
        ST_DATA: begin
          if (beat_fire && !resp_bad) begin
            beat_cnt <= beat_cnt + 9'd1;
            if (last_beat) offset <= offset_sum[31:0];
          end
        end
        default: ;
      endcase

      if ((state_next != state) || ar_hs || beat_fire) begin
        tmo <= 16'd0;
      end else if (wait_cyc) begin
        tmo <= tmo + 16'd1;
      end
    end
  end

  always_comb begin
    o_wire_data       = '0;
    o_wire_data_valid = 4'd0;
    if (in_data) begin
      o_wire_data[idx*PARAM_DATA_ALIGN +: PARAM_DATA_ALIGN] = i_wire_M_AXI_RDATA;
      o_wire_data_valid[idx] = i_wire_M_AXI_RVALID;
    end
  end

  assign o_wire_done          = (state == ST_DONE);
  assign o_wire_error         = state[4];
  assign o_wire_error_type    = err_type;
  assign o_wire_M_AXI_ARID    = 1'b0;
  assign o_wire_M_AXI_ARADDR  = araddr_r;
  assign o_wire_M_AXI_ARLEN   = arlen_r;
  assign o_wire_M_AXI_ARSIZE  = 3'b010;
  assign o_wire_M_AXI_ARBURST = 2'b01;
  assign o_wire_M_AXI_ARLOCK  = 1'b0;
  assign o_wire_M_AXI_ARCACHE = 4'b0010;
  assign o_wire_M_AXI_ARPROT  = 3'd0;
  assign o_wire_M_AXI_ARQOS   = 4'd0;
  assign o_wire_M_AXI_ARVALID = (state == ST_ADDR);
  assign o_wire_M_AXI_RREADY  = rready_int;

endmodule

// File: tb/tb_painterengine_gpu_dma_reader.sv
// Bench for painterengine_gpu_dma_reader: vector table of whole transfers against a simple AXI slave,
// plus directed timeout, backpressure, response, RLAST and mid-burst reset sequences.
module tb_painterengine_gpu_dma_reader;

  logic         clk;
  logic         rst_n;
  logic [3:0]   router;
  logic [127:0] address, length;
  logic [3:0]   data_next;
  logic         arready, rid, rlast, rvalid;
  logic [31:0]  rdata;
  logic [1:0]   rresp;

  logic         done, error, arid, arlock, arvalid, rready;
  logic [127:0] data;
  logic [3:0]   data_valid, arcache, arqos;
  logic [2:0]   error_type, arsize, arprot;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [1:0]   arburst;

  painterengine_gpu_dma_reader dut (
    .i_wire_clock(clk), .i_wire_resetn(rst_n), .i_wire_router(router), .o_wire_done(done),
    .i_wire_address(address), .i_wire_length(length), .o_wire_data(data),
    .o_wire_data_valid(data_valid), .i_wire_data_next(data_next), .o_wire_error(error),
    .o_wire_error_type(error_type), .o_wire_M_AXI_ARID(arid), .o_wire_M_AXI_ARADDR(araddr),
    .o_wire_M_AXI_ARLEN(arlen), .o_wire_M_AXI_ARSIZE(arsize), .o_wire_M_AXI_ARBURST(arburst),
    .o_wire_M_AXI_ARLOCK(arlock), .o_wire_M_AXI_ARCACHE(arcache), .o_wire_M_AXI_ARPROT(arprot),
    .o_wire_M_AXI_ARQOS(arqos), .o_wire_M_AXI_ARVALID(arvalid), .i_wire_M_AXI_ARREADY(arready),
    .i_wire_M_AXI_RID(rid), .i_wire_M_AXI_RDATA(rdata), .i_wire_M_AXI_RRESP(rresp),
    .i_wire_M_AXI_RLAST(rlast), .i_wire_M_AXI_RVALID(rvalid), .o_wire_M_AXI_RREADY(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  int          n_ar, n_beats, first_ar_cyc, gap2, err_cyc, last_beat_cyc;
  logic [31:0] ar_addr_a [8];
  logic [7:0]  ar_len_a [8];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    router = 4'd0; address = '0; length = '0; data_next = 4'd0;
    arready = 1'b0; rid = 1'b0; rlast = 1'b0; rvalid = 1'b0; rdata = 32'd0; rresp = 2'd0;
  endtask

  // Resets the DUT, starts one transfer and plays a single-outstanding AXI slave.
  task automatic run_xfer(input logic [3:0] rt, input logic [1:0] lane, input logic [31:0] a,
                          input logic [31:0] len, input bit arready_en, input bit rvalid_en,
                          input int stall_until, input int rresp_bad, input int rlast_bad,
                          input int abort_at, input int budget);
    int beats_left, beat_in_burst, cyc;
    logic [31:0] cur;
    bit arv_prev, finished;
    beats_left = 0; beat_in_burst = 0; cur = 32'd0; arv_prev = 1'b0; finished = 1'b0;
    n_ar = 0; n_beats = 0; first_ar_cyc = -1; gap2 = -1; err_cyc = -1; last_beat_cyc = -1;
    drive_idle();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // Unselected lanes carry a misaligned address and zero length so a wrong lane errors out.
    for (int l = 0; l < 4; l++) begin
      address[l*32 +: 32] = (l == int'(lane)) ? a : 32'h0000_0FF2;
      length[l*32 +: 32]  = (l == int'(lane)) ? len : 32'd0;
    end
    router = rt;
    cyc = 0;
    while (cyc < budget && !finished) begin
      @(negedge clk);
      cyc++;
      if (cyc == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("abort_arvalid", 128'(arvalid), 128'd0);
        check("abort_rready", 128'(rready), 128'd0);
        check("abort_valid", 128'(data_valid), 128'd0);
        check("abort_data", data, 128'd0);
        check("abort_done_err", 128'({done, error}), 128'd0);
        finished = 1'b1;
      end else if (done || error) begin
        if (error) err_cyc = cyc;
        finished = 1'b1;
      end else begin
        arready = 1'b0;
        if (arvalid) begin
          if (!arv_prev) begin
            if (n_ar == 0) first_ar_cyc = cyc;
            else if (n_ar == 1) gap2 = cyc - last_beat_cyc;
          end
          if (arready_en && n_ar < 8) begin
            arready = 1'b1;
            ar_addr_a[n_ar] = araddr;
            ar_len_a[n_ar]  = arlen;
            n_ar++;
            beats_left = int'(arlen) + 1;
            beat_in_burst = 0;
            cur = araddr;
          end
        end
        arv_prev  = arvalid;
        data_next = (cyc >= stall_until) ? 4'hF : 4'h0;
        if (beats_left > 0 && rvalid_en) begin
          rvalid = 1'b1;
          rdata  = cur ^ 32'h5A5A_0000;
          rresp  = (n_beats + 1 == rresp_bad) ? 2'b10 : 2'b00;
          rlast  = (beats_left == 1) || (beat_in_burst + 1 == rlast_bad);
        end else begin
          rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        end
        #1;
        if (rvalid && rready) begin
          check("lane_data", data, 128'(rdata) << (32 * int'(lane)));
          check("lane_valid", 128'(data_valid), 128'(4'b0001 << lane));
          n_beats++; beats_left--; beat_in_burst++;
          cur = cur + 32'd4;
          last_beat_cyc = cyc;
        end
      end
    end
    if (!finished) begin
      n_vec++; n_bad++;
      $display("FAIL budget: transfer did not finish within %0d cycles", budget);
    end
    drive_idle();
  endtask

  typedef struct {
    logic [3:0]  rt;
    logic [1:0]  lane;
    logic [31:0] a;
    logic [31:0] len;
    bit          exp_done;
    logic [2:0]  exp_type;
    int          exp_nar;
    logic [31:0] a0, a1, a2;
    logic [7:0]  l0, l1, l2;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [31:0] ea [3];
    logic [7:0]  el [3];
    vecs[0] = '{4'd2, 2'd1, 32'h1000, 32'd8,   1'b1, 3'd0, 1, 32'h1000, 32'h0,   32'h0,   8'd7,   8'd0,   8'd0};
    vecs[1] = '{4'd1, 2'd0, 32'h03F8, 32'd4,   1'b1, 3'd0, 2, 32'h03F8, 32'h400, 32'h0,   8'd1,   8'd1,   8'd0};
    vecs[2] = '{4'd4, 2'd2, 32'h0000, 32'd600, 1'b1, 3'd0, 3, 32'h0000, 32'h400, 32'h800, 8'd255, 8'd255, 8'd87};
    vecs[3] = '{4'd8, 2'd3, 32'h1002, 32'd4,   1'b0, 3'd2, 0, 32'h0,    32'h0,   32'h0,   8'd0,   8'd0,   8'd0};
    vecs[4] = '{4'd3, 2'd0, 32'h0100, 32'd4,   1'b0, 3'd1, 0, 32'h0,    32'h0,   32'h0,   8'd0,   8'd0,   8'd0};
    vecs[5] = '{4'd1, 2'd0, 32'h0100, 32'd0,   1'b0, 3'd3, 0, 32'h0,    32'h0,   32'h0,   8'd0,   8'd0,   8'd0};
    vecs[6] = '{4'd8, 2'd3, 32'h2000, 32'd3,   1'b1, 3'd0, 1, 32'h2000, 32'h0,   32'h0,   8'd2,   8'd0,   8'd0};
    vecs[7] = '{4'd2, 2'd1, 32'h0400, 32'd256, 1'b1, 3'd0, 1, 32'h0400, 32'h0,   32'h0,   8'd255, 8'd0,   8'd0};

    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_done", 128'(done), 128'd0);
    check("rst_error", 128'({error, error_type}), 128'd0);
    check("rst_arvalid_rready", 128'({arvalid, rready}), 128'd0);
    check("rst_data", data, 128'd0);
    check("rst_valid", 128'(data_valid), 128'd0);
    check("rst_ar_fields", 128'({araddr, arlen}), 128'd0);
    check("rst_ar_consts", 128'({arid, arsize, arburst, arlock, arcache, arprot, arqos}),
          128'({1'b0, 3'b010, 2'b01, 1'b0, 4'b0010, 3'b000, 4'b0000}));

    for (int i = 0; i < 8; i++) begin
      run_xfer(vecs[i].rt, vecs[i].lane, vecs[i].a, vecs[i].len, 1'b1, 1'b1, 0, 0, 0, -1, 1500);
      ea = '{vecs[i].a0, vecs[i].a1, vecs[i].a2};
      el = '{vecs[i].l0, vecs[i].l1, vecs[i].l2};
      check($sformatf("v%0d_done", i), 128'(done), 128'(vecs[i].exp_done));
      check($sformatf("v%0d_error", i), 128'(error), 128'(vecs[i].exp_type != 3'd0));
      check($sformatf("v%0d_type", i), 128'(error_type), 128'(vecs[i].exp_type));
      check($sformatf("v%0d_nar", i), 128'(n_ar), 128'(vecs[i].exp_nar));
      check($sformatf("v%0d_beats", i), 128'(n_beats), vecs[i].exp_done ? 128'(vecs[i].len) : 128'd0);
      for (int j = 0; j < vecs[i].exp_nar && j < n_ar; j++) begin
        check($sformatf("v%0d_araddr%0d", i, j), 128'(ar_addr_a[j]), 128'(ea[j]));
        check($sformatf("v%0d_arlen%0d", i, j), 128'(ar_len_a[j]), 128'(el[j]));
      end
      if (vecs[i].exp_nar > 0) check($sformatf("v%0d_first_ar_lat", i), 128'(first_ar_cyc), 128'd4);
      if (vecs[i].exp_nar > 1) check($sformatf("v%0d_burst_gap", i), 128'(gap2), 128'd3);
      check($sformatf("v%0d_rready_idle", i), 128'({arvalid, rready}), 128'd0);
    end

    // ARREADY never given: error lands 256 cycles after ARVALID first shows.
    run_xfer(4'd1, 2'd0, 32'h0, 32'd4, 1'b0, 1'b1, 0, 0, 0, -1, 600);
    check("ar_tmo_type", 128'({error, error_type}), 128'({1'b1, 3'd4}));
    check("ar_tmo_cycles", 128'(err_cyc - first_ar_cyc), 128'd256);

    // RVALID never given: 256 idle cycles counted from DATA entry.
    run_xfer(4'd1, 2'd0, 32'h0, 32'd4, 1'b1, 1'b0, 0, 0, 0, -1, 600);
    check("r_tmo_type", 128'({error, error_type}), 128'({1'b1, 3'd5}));
    check("r_tmo_cycles", 128'(err_cyc - first_ar_cyc), 128'd257);

    // Consumer stalls for 1000 cycles with RVALID high: no timeout.
    run_xfer(4'd2, 2'd1, 32'h40, 32'd2, 1'b1, 1'b1, 1000, 0, 0, -1, 1500);
    check("stall_done", 128'({done, error, error_type}), 128'({1'b1, 1'b0, 3'd0}));
    check("stall_beats", 128'(n_beats), 128'd2);

    // SLVERR on the third beat.
    run_xfer(4'd1, 2'd0, 32'h0, 32'd8, 1'b1, 1'b1, 0, 3, 0, -1, 600);
    check("rresp_type", 128'({done, error, error_type}), 128'({1'b0, 1'b1, 3'd6}));
    check("rresp_beats", 128'(n_beats), 128'd3);

    // Early RLAST on beat 2 of a 4-beat burst.
    run_xfer(4'd1, 2'd0, 32'h0, 32'd4, 1'b1, 1'b1, 0, 0, 2, -1, 600);
`ifdef PAINTERENGINE_GPU_READER_RLAST_CHECK_EN
    check("rlast_result", 128'({done, error, error_type}), 128'({1'b0, 1'b1, 3'd7}));
`else
    check("rlast_result", 128'({done, error, error_type}), 128'({1'b1, 1'b0, 3'd0}));
`endif

    // Reset in the middle of a burst, then a normal transfer afterwards.
    run_xfer(4'd2, 2'd1, 32'h1000, 32'd8, 1'b1, 1'b1, 0, 0, 0, 8, 600);
    check("abort_beats_seen", 128'(n_beats > 0), 128'd1);
    run_xfer(4'd4, 2'd2, 32'h3000, 32'd5, 1'b1, 1'b1, 0, 0, 0, -1, 600);
    check("post_abort_done", 128'({done, error}), 128'({1'b1, 1'b0}));
    check("post_abort_ar", 128'({ar_addr_a[0], ar_len_a[0]}), 128'({32'h3000, 8'd4}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
